// File: rtl/wave_ch_regs_n_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wave_regs_pkg : register offsets, read-back masks, channel record |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package wave_regs_pkg;

   localparam int unsigned REGS_PER_CH = 5;
   localparam int          FREQ_W_MAX  = 16;

   localparam logic [2:0] REG_DAC     = 3'd0;
   localparam logic [2:0] REG_LEN     = 3'd1;
   localparam logic [2:0] REG_VOL     = 3'd2;
   localparam logic [2:0] REG_FREQ_LO = 3'd3;
   localparam logic [2:0] REG_CTRL    = 3'd4;

   // Bits with no storage behind them read back as 1.
   localparam logic [7:0] RD_MASK_DAC     = 8'h7F;
   localparam logic [7:0] RD_MASK_LEN     = 8'hFF;
   localparam logic [7:0] RD_MASK_VOL     = 8'h9F;
   localparam logic [7:0] RD_MASK_FREQ_LO = 8'hFF;
   localparam logic [7:0] RD_MASK_CTRL    = 8'hBF;

   typedef struct packed {
      logic                  dac;
      logic                  len_en;
      logic [1:0]            vol;
      logic [FREQ_W_MAX-1:0] freq;
   } ch_regs_t;

   function automatic logic [7:0] rd_value(input logic [2:0] off, input logic dac,
                                           input logic len_en, input logic [1:0] vol);
      logic [7:0] v;
      case (off)
         REG_DAC:     v = {dac, 7'h00} | RD_MASK_DAC;
         REG_LEN:     v = RD_MASK_LEN;
         REG_VOL:     v = {1'b0, vol, 5'h00} | RD_MASK_VOL;
         REG_FREQ_LO: v = RD_MASK_FREQ_LO;
         REG_CTRL:    v = {1'b0, len_en, 6'h00} | RD_MASK_CTRL;
         default:     v = 8'hFF;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wave_ch_regs_n_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wave_ch_regs_n_if : APU register bus between decode and the bank  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface wave_ch_regs_n_if #(
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] addr;
   logic              apu_wr;
   logic              ncpu_rd;
   logic [7:0]        wdata;
   logic [7:0]        rdata;
   logic              rd_oe;

   modport master (output addr, apu_wr, ncpu_rd, wdata, input rdata, rd_oe);
   modport slave  (input addr, apu_wr, ncpu_rd, wdata, output rdata, rd_oe);
endinterface
`default_nettype wire

// File: rtl/wave_ch_regs_n_slice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wave_ch_slice : one channel's registers, length counter, trigger  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wave_ch_slice
   import wave_regs_pkg::*;
#(
   parameter int LEN_W  = 8,
   parameter int FREQ_W = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       wr,
   input  logic [2:0] off,
   input  logic [7:0] wdata,
   input  logic       len_tick,
   output ch_regs_t   regs_o,
   output logic       active_o,
   output logic       trig_pulse_o
);

   logic              dac_q, dac_d, len_en_q, len_en_d;
   logic [1:0]        vol_q, vol_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
   logic              expired_q, expired_d, active_q, active_d, pulse_q, pulse_d;
   logic              wr_len, trig;

   always_comb begin
      dac_d     = dac_q;
      len_en_d  = len_en_q;
      vol_d     = vol_q;
      freq_d    = freq_q;
      len_cnt_d = len_cnt_q;
      expired_d = expired_q;
      active_d  = active_q;
      pulse_d   = 1'b0;
      wr_len    = wr && (off == REG_LEN);
      trig      = wr && (off == REG_CTRL) && wdata[7];

      if (!en) begin
         dac_d     = 1'b0;
         len_en_d  = 1'b0;
         vol_d     = '0;
         freq_d    = '0;
         len_cnt_d = '0;
         expired_d = 1'b0;
         active_d  = 1'b0;
      end else begin
         // A length load or a trigger on this edge swallows the tick.
         if (len_tick && len_en_q && !expired_q && !wr_len && !trig) begin
            len_cnt_d = len_cnt_q + 1'b1;
            if (&len_cnt_q) begin
               expired_d = 1'b1;
               active_d  = 1'b0;
            end
         end
         if (wr) begin
            case (off)
               REG_DAC: begin
                  dac_d = wdata[7];
                  if (!wdata[7]) active_d = 1'b0;
               end
               REG_LEN: begin
                  len_cnt_d = wdata[LEN_W-1:0];
                  expired_d = 1'b0;
               end
               REG_VOL:     vol_d = wdata[6:5];
               REG_FREQ_LO: freq_d[7:0] = wdata;
               REG_CTRL: begin
                  len_en_d            = wdata[6];
                  freq_d[FREQ_W-1:8]  = wdata[FREQ_W-9:0];
                  if (wdata[7]) begin
                     if (expired_q) begin
                        len_cnt_d = '0;
                        expired_d = 1'b0;
                     end
                     active_d = dac_q;
                     pulse_d  = dac_q;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_q     <= 1'b0;
         len_en_q  <= 1'b0;
         vol_q     <= '0;
         freq_q    <= '0;
         len_cnt_q <= '0;
         expired_q <= 1'b0;
         active_q  <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         dac_q     <= dac_d;
         len_en_q  <= len_en_d;
         vol_q     <= vol_d;
         freq_q    <= freq_d;
         len_cnt_q <= len_cnt_d;
         expired_q <= expired_d;
         active_q  <= active_d;
         pulse_q   <= pulse_d;
      end
   end

   assign regs_o       = {dac_q, len_en_q, vol_q, FREQ_W_MAX'(freq_q)};
   assign active_o     = active_q;
   assign trig_pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/wave_ch_regs_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wave_ch_regs_n : NCH wave-channel register bank, decode + readback|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wave_ch_regs_n
   import wave_regs_pkg::*;
#(
   parameter int NCH    = 1,
   parameter int LEN_W  = 8,
   parameter int FREQ_W = 11,
   parameter int ADDR_W = $clog2(NCH * REGS_PER_CH)
) (
   input  logic                  apu_clk,
   input  logic                  napu_reset,
   input  logic                  apu_en,
   wave_ch_regs_n_if.slave       bus,
   input  logic                  len_tick,
   output logic [NCH-1:0]        dac_en,
   output logic [NCH-1:0]        ch_active,
   output logic [NCH*2-1:0]      ch_vol,
   output logic [NCH*FREQ_W-1:0] ch_freq,
   output logic [NCH-1:0]        trig_pulse
);

   int unsigned addr_u, ch_sel;
   logic [2:0]  off;
   logic        addr_ok;
   ch_regs_t    ch_regs [NCH];
   logic [NCH-1:0] freq_unused;
   logic        sel_dac, sel_len_en;
   logic [1:0]  sel_vol;
   logic [7:0]  rdata_q, rdata_d;
   logic        rd_oe_q, rd_oe_d;

   always_comb begin
      addr_u  = 32'(bus.addr);
      ch_sel  = addr_u / REGS_PER_CH;
      off     = 3'(addr_u % REGS_PER_CH);
      addr_ok = addr_u < NCH * REGS_PER_CH;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic wr_c;
      assign wr_c = apu_en && bus.apu_wr && addr_ok && (ch_sel == c);

      wave_ch_slice #(.LEN_W(LEN_W), .FREQ_W(FREQ_W)) u_slice (
         .clk          (apu_clk),
         .rst_n        (napu_reset),
         .en           (apu_en),
         .wr           (wr_c),
         .off          (off),
         .wdata        (bus.wdata),
         .len_tick     (len_tick),
         .regs_o       (ch_regs[c]),
         .active_o     (ch_active[c]),
         .trig_pulse_o (trig_pulse[c])
      );

      assign dac_en[c]                  = ch_regs[c].dac;
      assign ch_vol[2*c +: 2]           = ch_regs[c].vol;
      assign ch_freq[FREQ_W*c +: FREQ_W] = ch_regs[c].freq[FREQ_W-1:0];
      assign freq_unused[c]             = ^ch_regs[c].freq;
   end

   // Read-back samples pre-edge register values, so a same-cycle write is not visible.
   always_comb begin
      sel_dac    = 1'b0;
      sel_len_en = 1'b0;
      sel_vol    = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ch_sel == c) begin
            sel_dac    = ch_regs[c].dac;
            sel_len_en = ch_regs[c].len_en;
            sel_vol    = ch_regs[c].vol;
         end
      end
      rdata_d = '0;
      rd_oe_d = 1'b0;
      if (apu_en && !bus.ncpu_rd && addr_ok) begin
         rd_oe_d = 1'b1;
         rdata_d = rd_value(off, sel_dac, sel_len_en, sel_vol);
      end
   end

   always_ff @(posedge apu_clk or negedge napu_reset) begin
      if (!napu_reset) begin
         rdata_q <= '0;
         rd_oe_q <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         rd_oe_q <= rd_oe_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.rd_oe = rd_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_ch_regs_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wave_ch_regs_n : directed bench for a two-channel wave bank    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_wave_ch_regs_n;

   localparam int NCH = 2;
   localparam int FREQ_W = 11;

   logic apu_clk = 1'b0;
   logic napu_reset = 1'b1;
   logic apu_en = 1'b0;
   logic len_tick = 1'b0;
   logic [NCH-1:0]        dac_en, ch_active, trig_pulse;
   logic [NCH*2-1:0]      ch_vol;
   logic [NCH*FREQ_W-1:0] ch_freq;

   int n_pass = 0;
   int n_total = 0;

   wave_ch_regs_n_if #(.ADDR_W(4)) bus ();

   wave_ch_regs_n #(.NCH(NCH), .LEN_W(8), .FREQ_W(FREQ_W)) dut (
      .apu_clk    (apu_clk),
      .napu_reset (napu_reset),
      .apu_en     (apu_en),
      .bus        (bus),
      .len_tick   (len_tick),
      .dac_en     (dac_en),
      .ch_active  (ch_active),
      .ch_vol     (ch_vol),
      .ch_freq    (ch_freq),
      .trig_pulse (trig_pulse)
   );

   always #5 apu_clk = ~apu_clk;

   typedef struct {
      logic [3:0] addr;
      logic       wr;
      logic       rd;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_oe;
      logic [1:0] exp_act;
      logic [1:0] exp_pulse;
      logic [1:0] exp_dac;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge apu_clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic tick);
      bus.addr = a; bus.wdata = d; bus.apu_wr = 1'b1; len_tick = tick;
      cyc();
      bus.apu_wr = 1'b0; len_tick = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      bus.addr = a; bus.ncpu_rd = 1'b0;
      cyc();
      bus.ncpu_rd = 1'b1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         len_tick = 1'b1;
         cyc();
         len_tick = 1'b0;
      end
   endtask

   initial begin
      bus.addr = '0; bus.apu_wr = 1'b0; bus.ncpu_rd = 1'b1; bus.wdata = '0;

      //                 addr  wr  rd  wdata   rdata  oe  act    pulse  dac
      vecs[0]  = '{4'd0,  1, 0, 8'h80, 8'h00, 0, 2'b00, 2'b00, 2'b01};
      vecs[1]  = '{4'd2,  1, 0, 8'h20, 8'h00, 0, 2'b00, 2'b00, 2'b01};
      vecs[2]  = '{4'd3,  1, 0, 8'h34, 8'h00, 0, 2'b00, 2'b00, 2'b01};
      vecs[3]  = '{4'd4,  1, 0, 8'h87, 8'h00, 0, 2'b01, 2'b01, 2'b01};
      vecs[4]  = '{4'd0,  0, 0, 8'h00, 8'h00, 0, 2'b01, 2'b00, 2'b01};
      vecs[5]  = '{4'd0,  0, 1, 8'h00, 8'hFF, 1, 2'b01, 2'b00, 2'b01};
      vecs[6]  = '{4'd2,  0, 1, 8'h00, 8'hBF, 1, 2'b01, 2'b00, 2'b01};
      vecs[7]  = '{4'd4,  0, 1, 8'h00, 8'hBF, 1, 2'b01, 2'b00, 2'b01};
      vecs[8]  = '{4'd10, 0, 1, 8'h00, 8'h00, 0, 2'b01, 2'b00, 2'b01};
      vecs[9]  = '{4'd9,  0, 1, 8'h00, 8'hBF, 1, 2'b01, 2'b00, 2'b01};
      vecs[10] = '{4'd5,  0, 1, 8'h00, 8'h7F, 1, 2'b01, 2'b00, 2'b01};
      vecs[11] = '{4'd0,  0, 0, 8'h00, 8'h00, 0, 2'b01, 2'b00, 2'b01};

      // Reset state
      #3 napu_reset = 1'b0;
      #1;
      chk("rst_active", 32'(ch_active), 32'h0);
      chk("rst_dac", 32'(dac_en), 32'h0);
      chk("rst_oe", 32'(bus.rd_oe), 32'h0);
      #10 napu_reset = 1'b1;
      apu_en = 1'b1;
      @(negedge apu_clk);

      foreach (vecs[i]) begin
         bus.addr = vecs[i].addr; bus.wdata = vecs[i].wdata;
         bus.apu_wr = vecs[i].wr; bus.ncpu_rd = !vecs[i].rd;
         cyc();
         bus.apu_wr = 1'b0; bus.ncpu_rd = 1'b1;
         chk($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rdata));
         chk($sformatf("v%0d_oe", i), 32'(bus.rd_oe), 32'(vecs[i].exp_oe));
         chk($sformatf("v%0d_act", i), 32'(ch_active), 32'(vecs[i].exp_act));
         chk($sformatf("v%0d_pulse", i), 32'(trig_pulse), 32'(vecs[i].exp_pulse));
         chk($sformatf("v%0d_dac", i), 32'(dac_en), 32'(vecs[i].exp_dac));
      end
      chk("trig_freq", 32'(ch_freq), {10'h0, 11'h000, 11'h734});
      chk("trig_vol", 32'(ch_vol), 32'h1);

      // Length expiry and retrigger from zero
      wr(4'd1, 8'hFE, 1'b0);
      wr(4'd4, 8'hC0, 1'b0);
      chk("len_trig_pulse", 32'(trig_pulse), 32'h1);
      ticks(1);
      chk("len_tick1_act", 32'(ch_active), 32'h1);
      ticks(1);
      chk("len_expire_act", 32'(ch_active), 32'h0);
      wr(4'd4, 8'hC0, 1'b0);
      chk("retrig_act", 32'(ch_active), 32'h1);
      ticks(255);
      chk("retrig_255_act", 32'(ch_active), 32'h1);
      ticks(1);
      chk("retrig_256_act", 32'(ch_active), 32'h0);

      // Length load beats a same-edge tick
      wr(4'd4, 8'hC0, 1'b0);
      wr(4'd1, 8'hFE, 1'b1);
      ticks(1);
      chk("coll_load_act1", 32'(ch_active), 32'h1);
      ticks(1);
      chk("coll_load_act2", 32'(ch_active), 32'h0);

      // Trigger beats a same-edge tick
      wr(4'd1, 8'hFF, 1'b0);
      wr(4'd4, 8'hC0, 1'b1);
      chk("coll_trig_act", 32'(ch_active), 32'h1);
      ticks(1);
      chk("coll_trig_expire", 32'(ch_active), 32'h0);
      rd(4'd4);
      chk("rd_ctrl_len_en", 32'(bus.rdata), 32'hFF);

      // DAC off
      wr(4'd4, 8'hC0, 1'b0);
      chk("dac_pre_act", 32'(ch_active), 32'h1);
      wr(4'd0, 8'h00, 1'b0);
      chk("dac_off_act", 32'(ch_active), 32'h0);
      wr(4'd4, 8'h80, 1'b0);
      chk("dac_off_pulse", 32'(trig_pulse), 32'h0);
      chk("dac_off_trig_act", 32'(ch_active), 32'h0);

      // Simultaneous read and write returns the old value
      bus.addr = 4'd2; bus.wdata = 8'h40; bus.apu_wr = 1'b1; bus.ncpu_rd = 1'b0;
      cyc();
      bus.apu_wr = 1'b0; bus.ncpu_rd = 1'b1;
      chk("rw_old_vol", 32'(bus.rdata), 32'hBF);
      rd(4'd2);
      chk("rw_new_vol", 32'(bus.rdata), 32'hDF);

      // Channel 1 isolation
      wr(4'd0, 8'h80, 1'b0);
      wr(4'd5, 8'h80, 1'b0);
      wr(4'd8, 8'h55, 1'b0);
      wr(4'd9, 8'h82, 1'b0);
      chk("ch1_pulse", 32'(trig_pulse), 32'h2);
      chk("ch1_act", 32'(ch_active), 32'h2);
      chk("ch1_freq", 32'(ch_freq), {10'h0, 11'h255, 11'h034});
      chk("ch1_vol", 32'(ch_vol), 32'h2);

      // Master enable clear; writes ignored while disabled
      apu_en = 1'b0;
      wr(4'd0, 8'h80, 1'b0);
      chk("en0_act", 32'(ch_active), 32'h0);
      chk("en0_dac", 32'(dac_en), 32'h0);
      chk("en0_freq", 32'(ch_freq), 32'h0);
      chk("en0_vol", 32'(ch_vol), 32'h0);
      apu_en = 1'b1;
      ticks(2);
      chk("en1_no_resume", 32'(ch_active), 32'h0);

      // Asynchronous reset mid-run
      wr(4'd0, 8'h80, 1'b0);
      wr(4'd4, 8'h80, 1'b0);
      chk("pre_rst_act", 32'(ch_active), 32'h1);
      #2 napu_reset = 1'b0;
      #1;
      chk("async_rst_act", 32'(ch_active), 32'h0);
      chk("async_rst_dac", 32'(dac_en), 32'h0);
      @(negedge apu_clk);
      napu_reset = 1'b1;
      rd(4'd0);
      chk("post_rst_rd0", 32'(bus.rdata), 32'h7F);
      chk("post_rst_oe", 32'(bus.rd_oe), 32'h1);
      cyc();
      chk("oe_one_cycle", 32'(bus.rd_oe), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
